// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes, FSM encodings and master ids for the read/write arbiter.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_AW   = 2'd1,
    WR_B    = 2'd2
  } wr_state_t;

  typedef enum logic {
    MST_IF  = 1'b0,
    MST_LSU = 1'b1
  } mst_id_t;

  // On a tie the master that did not win last time goes next, unless LSU is pinned on top.
  function automatic mst_id_t pick_grant(input logic req_if, input logic req_lsu,
                                         input mst_id_t last_grant, input logic fixed_prio);
    mst_id_t pick;
    pick = MST_IF;
    if (req_if && req_lsu) begin
      if (fixed_prio) pick = MST_LSU;
      else            pick = (last_grant == MST_LSU) ? MST_IF : MST_LSU;
    end else if (req_lsu) begin
      pick = MST_LSU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way read arbiter: registers the grant when loaded and remembers the last completed owner.
module axi_rr_arb2
  import axi4_lite_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_if,
  input  logic    req_lsu,
  input  logic    load,
  input  logic    release_grant,
  output mst_id_t grant
);

  mst_id_t last_grant;
  mst_id_t next_grant;

  assign next_grant = pick_grant(req_if, req_lsu, last_grant, FIXED_PRIO != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    grant <= MST_IF;
    else if (load) grant <= next_grant;
  end

  // Reset to LSU so the fetch port wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             last_grant <= MST_LSU;
    else if (release_grant) last_grant <= grant;
  end

endmodule

// File: rtl/axi4_lite_rd_arbiter.sv
// Shares one AXI4-Lite master port between the fetch (read-only) and LSU (read/write) ports.
// Define AXI_ARB_PERF_CNT_EN to add per-master completed-transaction counters.
module axi4_lite_rd_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0
`ifdef AXI_ARB_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH  = 32
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [ADDR_WIDTH-1:0]   M0_AXI_ARADDR,
  input  logic [2:0]              M0_AXI_ARPROT,
  input  logic                    M0_AXI_ARVALID,
  output logic                    M0_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   M0_AXI_RDATA,
  output logic [1:0]              M0_AXI_RRESP,
  output logic                    M0_AXI_RVALID,
  input  logic                    M0_AXI_RREADY,

  input  logic [ADDR_WIDTH-1:0]   M1_AXI_ARADDR,
  input  logic [2:0]              M1_AXI_ARPROT,
  input  logic                    M1_AXI_ARVALID,
  output logic                    M1_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   M1_AXI_RDATA,
  output logic [1:0]              M1_AXI_RRESP,
  output logic                    M1_AXI_RVALID,
  input  logic                    M1_AXI_RREADY,
  input  logic [ADDR_WIDTH-1:0]   M1_AXI_AWADDR,
  input  logic [2:0]              M1_AXI_AWPROT,
  input  logic                    M1_AXI_AWVALID,
  output logic                    M1_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   M1_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] M1_AXI_WSTRB,
  input  logic                    M1_AXI_WVALID,
  output logic                    M1_AXI_WREADY,
  output logic [1:0]              M1_AXI_BRESP,
  output logic                    M1_AXI_BVALID,
  input  logic                    M1_AXI_BREADY,

  output logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  output logic [2:0]              S_AXI_ARPROT,
  output logic                    S_AXI_ARVALID,
  input  logic                    S_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  input  logic [1:0]              S_AXI_RRESP,
  input  logic                    S_AXI_RVALID,
  output logic                    S_AXI_RREADY,
  output logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  output logic [2:0]              S_AXI_AWPROT,
  output logic                    S_AXI_AWVALID,
  input  logic                    S_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  output logic                    S_AXI_WVALID,
  input  logic                    S_AXI_WREADY,
  input  logic [1:0]              S_AXI_BRESP,
  input  logic                    S_AXI_BVALID,
  output logic                    S_AXI_BREADY
`ifdef AXI_ARB_PERF_CNT_EN
  ,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    m0_rd_cnt,
  output logic [CNT_WIDTH-1:0]    m1_rd_cnt,
  output logic [CNT_WIDTH-1:0]    m1_wr_cnt
`endif
);

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;
  mst_id_t   rd_grant;
  logic      ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic      aw_done, w_done;

  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign b_hs  = S_AXI_BVALID  && S_AXI_BREADY;

  axi_rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_rd_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_if       (M0_AXI_ARVALID),
    .req_lsu      (M1_AXI_ARVALID),
    .load         ((rd_state == RD_IDLE) && (M0_AXI_ARVALID || M1_AXI_ARVALID)),
    .release_grant((rd_state == RD_DATA) && r_hs),
    .grant        (rd_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      RD_IDLE: if (M0_AXI_ARVALID || M1_AXI_ARVALID) rd_next = RD_ADDR;
      RD_ADDR: if (ar_hs) rd_next = RD_DATA;
      RD_DATA: if (r_hs)  rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // Only the granted master sees the slave; the other side is held at zero.
  always_comb begin
    S_AXI_ARADDR   = '0;
    S_AXI_ARPROT   = '0;
    S_AXI_ARVALID  = 1'b0;
    S_AXI_RREADY   = 1'b0;
    M0_AXI_ARREADY = 1'b0;
    M1_AXI_ARREADY = 1'b0;
    M0_AXI_RDATA   = '0;
    M0_AXI_RRESP   = RESP_OKAY;
    M0_AXI_RVALID  = 1'b0;
    M1_AXI_RDATA   = '0;
    M1_AXI_RRESP   = RESP_OKAY;
    M1_AXI_RVALID  = 1'b0;
    unique case (rd_state)
      RD_ADDR: begin
        if (rd_grant == MST_LSU) begin
          S_AXI_ARADDR   = M1_AXI_ARADDR;
          S_AXI_ARPROT   = M1_AXI_ARPROT;
          S_AXI_ARVALID  = M1_AXI_ARVALID;
          M1_AXI_ARREADY = S_AXI_ARREADY;
        end else begin
          S_AXI_ARADDR   = M0_AXI_ARADDR;
          S_AXI_ARPROT   = M0_AXI_ARPROT;
          S_AXI_ARVALID  = M0_AXI_ARVALID;
          M0_AXI_ARREADY = S_AXI_ARREADY;
        end
      end
      RD_DATA: begin
        if (rd_grant == MST_LSU) begin
          M1_AXI_RDATA  = S_AXI_RDATA;
          M1_AXI_RRESP  = S_AXI_RRESP;
          M1_AXI_RVALID = S_AXI_RVALID;
          S_AXI_RREADY  = M1_AXI_RREADY;
        end else begin
          M0_AXI_RDATA  = S_AXI_RDATA;
          M0_AXI_RRESP  = S_AXI_RRESP;
          M0_AXI_RVALID = S_AXI_RVALID;
          S_AXI_RREADY  = M0_AXI_RREADY;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_state <= WR_IDLE;
    else        wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      WR_IDLE: if (M1_AXI_AWVALID) wr_next = WR_AW;
      WR_AW:   if ((aw_done || aw_hs) && (w_done || w_hs)) wr_next = WR_B;
      WR_B:    if (b_hs) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  // AW and W finish independently; remember each so neither channel is reissued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if ((wr_state == WR_B) && b_hs) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  always_comb begin
    S_AXI_AWADDR   = '0;
    S_AXI_AWPROT   = '0;
    S_AXI_AWVALID  = 1'b0;
    S_AXI_WDATA    = '0;
    S_AXI_WSTRB    = '0;
    S_AXI_WVALID   = 1'b0;
    S_AXI_BREADY   = 1'b0;
    M1_AXI_AWREADY = 1'b0;
    M1_AXI_WREADY  = 1'b0;
    M1_AXI_BRESP   = RESP_OKAY;
    M1_AXI_BVALID  = 1'b0;
    unique case (wr_state)
      WR_AW: begin
        S_AXI_AWADDR   = M1_AXI_AWADDR;
        S_AXI_AWPROT   = M1_AXI_AWPROT;
        S_AXI_AWVALID  = M1_AXI_AWVALID && !aw_done;
        M1_AXI_AWREADY = S_AXI_AWREADY && !aw_done;
        S_AXI_WDATA    = M1_AXI_WDATA;
        S_AXI_WSTRB    = M1_AXI_WSTRB;
        S_AXI_WVALID   = M1_AXI_WVALID && !w_done;
        M1_AXI_WREADY  = S_AXI_WREADY && !w_done;
      end
      WR_B: begin
        M1_AXI_BRESP  = S_AXI_BRESP;
        M1_AXI_BVALID = S_AXI_BVALID;
        S_AXI_BREADY  = M1_AXI_BREADY;
      end
      default: ;
    endcase
  end

`ifdef AXI_ARB_PERF_CNT_EN
  // Clear beats increment so software can zero the counters mid-traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rd_cnt <= '0;
      m1_rd_cnt <= '0;
      m1_wr_cnt <= '0;
    end else if (cnt_clr) begin
      m0_rd_cnt <= '0;
      m1_rd_cnt <= '0;
      m1_wr_cnt <= '0;
    end else begin
      if (M0_AXI_RVALID && M0_AXI_RREADY) m0_rd_cnt <= m0_rd_cnt + CNT_WIDTH'(1);
      if (M1_AXI_RVALID && M1_AXI_RREADY) m1_rd_cnt <= m1_rd_cnt + CNT_WIDTH'(1);
      if (M1_AXI_BVALID && M1_AXI_BREADY) m1_wr_cnt <= m1_wr_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axi4_lite_rd_arbiter.sv
// Directed cycle-by-cycle bench for axi4_lite_rd_arbiter; the bench itself plays the slave.
module tb_axi4_lite_rd_arbiter;
  import axi4_lite_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic [31:0] M0_AXI_ARADDR, M1_AXI_ARADDR, M1_AXI_AWADDR, M1_AXI_WDATA;
  logic [2:0]  M0_AXI_ARPROT, M1_AXI_ARPROT, M1_AXI_AWPROT;
  logic        M0_AXI_ARVALID, M0_AXI_ARREADY, M0_AXI_RVALID, M0_AXI_RREADY;
  logic [31:0] M0_AXI_RDATA, M1_AXI_RDATA;
  logic [1:0]  M0_AXI_RRESP, M1_AXI_RRESP, M1_AXI_BRESP;
  logic        M1_AXI_ARVALID, M1_AXI_ARREADY, M1_AXI_RVALID, M1_AXI_RREADY;
  logic        M1_AXI_AWVALID, M1_AXI_AWREADY, M1_AXI_WVALID, M1_AXI_WREADY;
  logic [3:0]  M1_AXI_WSTRB;
  logic        M1_AXI_BVALID, M1_AXI_BREADY;

  logic [31:0] S_AXI_ARADDR, S_AXI_RDATA, S_AXI_AWADDR, S_AXI_WDATA;
  logic [2:0]  S_AXI_ARPROT, S_AXI_AWPROT;
  logic        S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY;
  logic [1:0]  S_AXI_RRESP, S_AXI_BRESP;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_BVALID, S_AXI_BREADY;
`ifdef AXI_ARB_PERF_CNT_EN
  logic        cnt_clr;
  logic [31:0] m0_rd_cnt, m1_rd_cnt, m1_wr_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_lite_rd_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .FIXED_PRIO(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .M0_AXI_ARADDR(M0_AXI_ARADDR), .M0_AXI_ARPROT(M0_AXI_ARPROT),
    .M0_AXI_ARVALID(M0_AXI_ARVALID), .M0_AXI_ARREADY(M0_AXI_ARREADY),
    .M0_AXI_RDATA(M0_AXI_RDATA), .M0_AXI_RRESP(M0_AXI_RRESP),
    .M0_AXI_RVALID(M0_AXI_RVALID), .M0_AXI_RREADY(M0_AXI_RREADY),
    .M1_AXI_ARADDR(M1_AXI_ARADDR), .M1_AXI_ARPROT(M1_AXI_ARPROT),
    .M1_AXI_ARVALID(M1_AXI_ARVALID), .M1_AXI_ARREADY(M1_AXI_ARREADY),
    .M1_AXI_RDATA(M1_AXI_RDATA), .M1_AXI_RRESP(M1_AXI_RRESP),
    .M1_AXI_RVALID(M1_AXI_RVALID), .M1_AXI_RREADY(M1_AXI_RREADY),
    .M1_AXI_AWADDR(M1_AXI_AWADDR), .M1_AXI_AWPROT(M1_AXI_AWPROT),
    .M1_AXI_AWVALID(M1_AXI_AWVALID), .M1_AXI_AWREADY(M1_AXI_AWREADY),
    .M1_AXI_WDATA(M1_AXI_WDATA), .M1_AXI_WSTRB(M1_AXI_WSTRB),
    .M1_AXI_WVALID(M1_AXI_WVALID), .M1_AXI_WREADY(M1_AXI_WREADY),
    .M1_AXI_BRESP(M1_AXI_BRESP), .M1_AXI_BVALID(M1_AXI_BVALID),
    .M1_AXI_BREADY(M1_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY)
`ifdef AXI_ARB_PERF_CNT_EN
    ,
    .cnt_clr(cnt_clr), .m0_rd_cnt(m0_rd_cnt), .m1_rd_cnt(m1_rd_cnt), .m1_wr_cnt(m1_wr_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive both read-address requests at once.
  task automatic applyStimulus(input logic m0_valid, input logic [31:0] m0_addr,
                               input logic m1_valid, input logic [31:0] m1_addr);
    M0_AXI_ARVALID = m0_valid;
    M0_AXI_ARADDR  = m0_addr;
    M1_AXI_ARVALID = m1_valid;
    M1_AXI_ARADDR  = m1_addr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    M0_AXI_ARPROT = '0; M1_AXI_ARPROT = '0; M1_AXI_AWPROT = 3'b010;
    M1_AXI_AWADDR = '0; M1_AXI_WDATA = '0; M1_AXI_WSTRB = '0;
    M1_AXI_AWVALID = 1'b0; M1_AXI_WVALID = 1'b1; M1_AXI_BREADY = 1'b1;
    M0_AXI_RREADY = 1'b1; M1_AXI_RREADY = 1'b1;
    S_AXI_ARREADY = 1'b1; S_AXI_RDATA = 32'hFFFF_FFFF; S_AXI_RRESP = RESP_OKAY;
    S_AXI_RVALID = 1'b1; S_AXI_AWREADY = 1'b1; S_AXI_WREADY = 1'b1;
    S_AXI_BRESP = RESP_OKAY; S_AXI_BVALID = 1'b1;
`ifdef AXI_ARB_PERF_CNT_EN
    cnt_clr = 1'b0;
`endif
    applyStimulus(1'b1, 32'h0000_0010, 1'b1, 32'h0000_0020);
    #2;
    checkOutput("rst_s_arvalid", S_AXI_ARVALID, 0);
    checkOutput("rst_m0_arready", M0_AXI_ARREADY, 0);
    checkOutput("rst_m0_rvalid", M0_AXI_RVALID, 0);
    checkOutput("rst_m0_rdata", M0_AXI_RDATA, 0);
    checkOutput("rst_s_rready", S_AXI_RREADY, 0);
    checkOutput("rst_m1_wready", M1_AXI_WREADY, 0);
    checkOutput("rst_m1_bvalid", M1_AXI_BVALID, 0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    S_AXI_RVALID = 1'b0; S_AXI_BVALID = 1'b0; M1_AXI_WVALID = 1'b0;
    #10 rst_n = 1'b1;
    next_cycle();

    // Tie after reset: fetch first, then a fresh fetch request ties with the waiting LSU.
    applyStimulus(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200);
    #1 checkOutput("tie_idle_s_arvalid", S_AXI_ARVALID, 0);
    next_cycle();
    checkOutput("tie1_s_araddr", S_AXI_ARADDR, 32'h0000_0100);
    checkOutput("tie1_m0_arready", M0_AXI_ARREADY, 1);
    checkOutput("tie1_m1_arready", M1_AXI_ARREADY, 0);
    next_cycle();
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_0200);
    S_AXI_RVALID = 1'b1; S_AXI_RDATA = 32'h1111_1111;
    #1 checkOutput("tie1_m0_rdata", M0_AXI_RDATA, 32'h1111_1111);
    checkOutput("tie1_m1_rvalid", M1_AXI_RVALID, 0);
    next_cycle();
    applyStimulus(1'b1, 32'h0000_0104, 1'b1, 32'h0000_0200);
    S_AXI_RVALID = 1'b0;
    #1 checkOutput("tie2_idle_gap", S_AXI_ARVALID, 0);
    next_cycle();
    checkOutput("tie2_s_araddr", S_AXI_ARADDR, 32'h0000_0200);
    checkOutput("tie2_m1_arready", M1_AXI_ARREADY, 1);
    checkOutput("tie2_m0_arready", M0_AXI_ARREADY, 0);
    next_cycle();
    applyStimulus(1'b1, 32'h0000_0104, 1'b0, '0);
    S_AXI_RVALID = 1'b1; S_AXI_RDATA = 32'h2222_2222;
    #1 checkOutput("tie2_m1_rdata", M1_AXI_RDATA, 32'h2222_2222);
    checkOutput("tie2_m0_rvalid", M0_AXI_RVALID, 0);
    next_cycle();
    S_AXI_RVALID = 1'b0;
    next_cycle();
    checkOutput("tie3_s_araddr", S_AXI_ARADDR, 32'h0000_0104);
    next_cycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    S_AXI_RVALID = 1'b1; S_AXI_RDATA = 32'h3333_3333;
    #1 checkOutput("tie3_m0_rdata", M0_AXI_RDATA, 32'h3333_3333);
    next_cycle();
    S_AXI_RVALID = 1'b0;

    // Single fetch read: address phase appears one cycle after ARVALID.
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, '0);
    #1 checkOutput("rd_lat_cycle_n", S_AXI_ARVALID, 0);
    next_cycle();
    checkOutput("rd_lat_cycle_n1", S_AXI_ARVALID, 1);
    checkOutput("rd_s_araddr", S_AXI_ARADDR, 32'h0000_0010);
    next_cycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    S_AXI_RVALID = 1'b1; S_AXI_RDATA = 32'h0050_0093; S_AXI_RRESP = RESP_OKAY;
    #1 checkOutput("rd_m0_rdata", M0_AXI_RDATA, 32'h0050_0093);
    checkOutput("rd_m0_rresp", M0_AXI_RRESP, RESP_OKAY);
    checkOutput("rd_m1_rvalid", M1_AXI_RVALID, 0);
    checkOutput("rd_s_arvalid_data", S_AXI_ARVALID, 0);
    next_cycle();
    S_AXI_RVALID = 1'b0;
    #1 checkOutput("rd_m0_rvalid_done", M0_AXI_RVALID, 0);

    // LSU read answered with DECERR passes through untouched.
    applyStimulus(1'b0, '0, 1'b1, 32'h2000_0000);
    next_cycle();
    checkOutput("dec_s_araddr", S_AXI_ARADDR, 32'h2000_0000);
    next_cycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    S_AXI_RVALID = 1'b1; S_AXI_RRESP = RESP_DECERR; S_AXI_RDATA = 32'hDEAD_BEEF;
    #1 checkOutput("dec_m1_rresp", M1_AXI_RRESP, 2'b11);
    checkOutput("dec_m1_rdata", M1_AXI_RDATA, 32'hDEAD_BEEF);
    next_cycle();
    S_AXI_RVALID = 1'b0; S_AXI_RRESP = RESP_OKAY;
    #1 checkOutput("dec_idle_m1_rvalid", M1_AXI_RVALID, 0);
    checkOutput("dec_idle_s_rready", S_AXI_RREADY, 0);

    // Write with W offered three cycles ahead of AW; AW completes before W.
    M1_AXI_WVALID = 1'b1; M1_AXI_WDATA = 32'hCAFE_BABE; M1_AXI_WSTRB = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("wr_early_w_held", M1_AXI_WREADY, 0);
      checkOutput("wr_early_s_wvalid", S_AXI_WVALID, 0);
      next_cycle();
    end
    M1_AXI_AWVALID = 1'b1; M1_AXI_AWADDR = 32'h1000_0004;
    #1 checkOutput("wr_idle_s_awvalid", S_AXI_AWVALID, 0);
    next_cycle();
    S_AXI_WREADY = 1'b0;
    #1 checkOutput("wr_s_awvalid", S_AXI_AWVALID, 1);
    checkOutput("wr_s_awaddr", S_AXI_AWADDR, 32'h1000_0004);
    checkOutput("wr_s_awprot", S_AXI_AWPROT, 3'b010);
    checkOutput("wr_s_wdata", S_AXI_WDATA, 32'hCAFE_BABE);
    checkOutput("wr_s_wstrb", S_AXI_WSTRB, 4'hF);
    checkOutput("wr_m1_wready_stall", M1_AXI_WREADY, 0);
    next_cycle();
    M1_AXI_AWVALID = 1'b0; S_AXI_WREADY = 1'b1;
    #1 checkOutput("wr_no_dup_awvalid", S_AXI_AWVALID, 0);
    checkOutput("wr_m1_wready", M1_AXI_WREADY, 1);
    checkOutput("wr_not_in_b_yet", S_AXI_BREADY, 0);
    next_cycle();
    M1_AXI_WVALID = 1'b0; S_AXI_BVALID = 1'b1; S_AXI_BRESP = RESP_OKAY;
    #1 checkOutput("wr_m1_bvalid", M1_AXI_BVALID, 1);
    checkOutput("wr_m1_bresp", M1_AXI_BRESP, RESP_OKAY);
    checkOutput("wr_s_bready", S_AXI_BREADY, 1);
    checkOutput("wr_b_s_wvalid", S_AXI_WVALID, 0);
    next_cycle();
    S_AXI_BVALID = 1'b0;
    #1 checkOutput("wr_done_m1_bvalid", M1_AXI_BVALID, 0);

    // Fetch read and LSU write in flight together.
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, '0);
    M1_AXI_AWVALID = 1'b1; M1_AXI_AWADDR = 32'h1000_0008;
    M1_AXI_WVALID = 1'b1; M1_AXI_WDATA = 32'h1234_5678;
    next_cycle();
    checkOutput("cc_s_arvalid_lat", S_AXI_ARVALID, 1);
    checkOutput("cc_s_awvalid", S_AXI_AWVALID, 1);
    checkOutput("cc_s_wvalid", S_AXI_WVALID, 1);
    next_cycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    M1_AXI_AWVALID = 1'b0; M1_AXI_WVALID = 1'b0;
    S_AXI_RVALID = 1'b1; S_AXI_RDATA = 32'hA5A5_A5A5;
    S_AXI_BVALID = 1'b1; S_AXI_BRESP = RESP_SLVERR;
    #1 checkOutput("cc_m0_rdata", M0_AXI_RDATA, 32'hA5A5_A5A5);
    checkOutput("cc_m1_bvalid", M1_AXI_BVALID, 1);
    checkOutput("cc_m1_bresp", M1_AXI_BRESP, RESP_SLVERR);
    next_cycle();
    S_AXI_RVALID = 1'b0; S_AXI_BVALID = 1'b0; S_AXI_BRESP = RESP_OKAY;
    #1 checkOutput("cc_m0_rvalid_done", M0_AXI_RVALID, 0);
    checkOutput("cc_m1_bvalid_done", M1_AXI_BVALID, 0);
`ifdef AXI_ARB_PERF_CNT_EN
    checkOutput("cnt_m0_rd", m0_rd_cnt, 4);
    checkOutput("cnt_m1_rd", m1_rd_cnt, 2);
    checkOutput("cnt_m1_wr", m1_wr_cnt, 2);
`endif

    // Reset while an LSU read response is pending.
    M1_AXI_RREADY = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_0300);
    next_cycle();
    next_cycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    S_AXI_RVALID = 1'b1; S_AXI_RDATA = 32'h55AA_55AA;
    #1 checkOutput("mid_m1_rvalid_pending", M1_AXI_RVALID, 1);
    #2 rst_n = 1'b0;
    #1 checkOutput("mid_rst_m1_rvalid", M1_AXI_RVALID, 0);
    checkOutput("mid_rst_m1_rdata", M1_AXI_RDATA, 0);
`ifdef AXI_ARB_PERF_CNT_EN
    checkOutput("mid_rst_cnt_m0", m0_rd_cnt, 0);
    checkOutput("mid_rst_cnt_m1_rd", m1_rd_cnt, 0);
    checkOutput("mid_rst_cnt_m1_wr", m1_wr_cnt, 0);
`endif
    S_AXI_RVALID = 1'b0; M1_AXI_RREADY = 1'b1;
    #2 rst_n = 1'b1;
    next_cycle();
    applyStimulus(1'b1, 32'h0000_0400, 1'b1, 32'h0000_0500);
    #1 checkOutput("post_rst_idle", S_AXI_ARVALID, 0);
    next_cycle();
    checkOutput("post_rst_tie_addr", S_AXI_ARADDR, 32'h0000_0400);
    checkOutput("post_rst_m0_arready", M0_AXI_ARREADY, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
